// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder
//   WIDTH-bit adder (a + b + cin -> WIDTH+1 bit result) whose carry chain is
//   cut into STAGES registered segments of SEG_W bits (last one takes the
//   remainder). Valid/ready on both sides with full backpressure; a stage that
//   holds no valid data always accepts, so bubbles collapse under a stall.
//   Optional macro PIPELINED_ADDER_SUB_MODE_EN adds in_sub: when set, B is
//   inverted and the carry-in forced to 1 at entry, so out_sum[WIDTH-1:0] is
//   a - b and out_sum[WIDTH] = 1 means no borrow. The subtract decision rides
//   down the pipeline inside the carried (already inverted) B bits.

module pipelined_ripple_adder #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef PIPELINED_ADDER_SUB_MODE_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int SEG_W = (WIDTH + STAGES - 1) / STAGES;

  // Stage registers: valid, carry out of the segment, partial sum, operands.
  logic [STAGES-1:0] r_v;
  logic              r_cy   [STAGES];
  logic [WIDTH-1:0]  r_psum [STAGES];
  logic [WIDTH-1:0]  r_a    [STAGES];
  logic [WIDTH-1:0]  r_b    [STAGES];

  // Upstream view of each stage and its combinational segment result.
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_up_v;
  logic              w_up_cy   [STAGES];
  logic [WIDTH-1:0]  w_up_psum [STAGES];
  logic [WIDTH-1:0]  w_up_a    [STAGES];
  logic [WIDTH-1:0]  w_up_b    [STAGES];
  logic              w_cy      [STAGES];
  logic [WIDTH-1:0]  w_psum    [STAGES];

  logic [WIDTH-1:0]  w_b0;
  logic              w_cin0;
  logic              w_adv_nxt;

  // Operand conditioning at pipeline entry (subtract = add inverted B plus one).
  always_comb begin
    w_b0   = in_b;
    w_cin0 = in_cin;
`ifdef PIPELINED_ADDER_SUB_MODE_EN
    if (in_sub) begin
      w_b0   = ~in_b;
      w_cin0 = 1'b1;
    end
`endif
  end

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    w_adv     = '0;
    w_adv_nxt = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv_nxt = !r_v[k] || w_adv_nxt;
      w_adv[k]  = w_adv_nxt;
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      localparam int LO = g * SEG_W;
      localparam int HI = ((g + 1) * SEG_W > WIDTH) ? WIDTH : (g + 1) * SEG_W;

      logic [WIDTH-1:0] w_seg_sum;
      logic             w_seg_cy;

      if (g == 0) begin : g_head
        assign w_up_v[g]    = in_valid;
        assign w_up_cy[g]   = w_cin0;
        assign w_up_psum[g] = '0;
        assign w_up_a[g]    = in_a;
        assign w_up_b[g]    = w_b0;
      end else begin : g_body
        assign w_up_v[g]    = r_v[g-1];
        assign w_up_cy[g]   = r_cy[g-1];
        assign w_up_psum[g] = r_psum[g-1];
        assign w_up_a[g]    = r_a[g-1];
        assign w_up_b[g]    = r_b[g-1];
      end

      // Ripple through this stage's bit slice [LO, HI); empty slices pass the carry.
      always_comb begin
        w_seg_cy  = w_up_cy[g];
        w_seg_sum = w_up_psum[g];
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= LO && i < HI) begin
            w_seg_sum[i] = w_up_a[g][i] ^ w_up_b[g][i] ^ w_seg_cy;
            w_seg_cy     = (w_up_a[g][i] & w_up_b[g][i]) |
                           (w_seg_cy & (w_up_a[g][i] ^ w_up_b[g][i]));
          end
        end
      end

      assign w_psum[g] = w_seg_sum;
      assign w_cy[g]   = w_seg_cy;
    end
  endgenerate

  // Stage registers: valid follows upstream on advance; data only loads with valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_cy[k]   <= 1'b0;
        r_psum[k] <= '0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= w_up_v[k];
          if (w_up_v[k]) begin
            r_cy[k]   <= w_cy[k];
            r_psum[k] <= w_psum[k];
            r_a[k]    <= w_up_a[k];
            r_b[k]    <= w_up_b[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[STAGES-1];
  assign out_sum   = {r_cy[STAGES-1], r_psum[STAGES-1]};

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder. Default build: WIDTH=3, STAGES=2.
// With PIPELINED_ADDER_SUB_MODE_EN defined: WIDTH=8, STAGES=3 and in_sub driven.
module tb_pipelined_ripple_adder;

`ifdef PIPELINED_ADDER_SUB_MODE_EN
  localparam int W = 8;
  localparam int S = 3;
`else
  localparam int W = 3;
  localparam int S = 2;
`endif
  localparam int N_VEC = 128;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
`ifdef PIPELINED_ADDER_SUB_MODE_EN
  logic         in_sub;
`endif

  logic [W:0] q[$];
  int n_tests = 0;
  int n_fail  = 0;

  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef PIPELINED_ADDER_SUB_MODE_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W:0]   r;
    logic [W-1:0] d;
    d = a - b;
    if (sub) r = {(a >= b), d};
    else     r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return r;
  endfunction

  // One cycle: drive at negedge, sample #1 later; report the transfers of the coming posedge.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic ordy,
                       output logic acc, output logic got, output logic [W:0] sum);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = ordy;
`ifdef PIPELINED_ADDER_SUB_MODE_EN
    in_sub    = sub;
`endif
    #1;
    acc = in_valid && in_ready;
    got = out_valid && out_ready;
    sum = out_sum;
    if (acc) q.push_back(model(a, b, cin, sub));
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int da[$], db[$], dc[$], ds[$], de[$];
    logic acc, got;
    logic [W:0] sum, exp_q;
    int lat;
`ifdef PIPELINED_ADDER_SUB_MODE_EN
    da = '{5, 200}; db = '{9, 55}; dc = '{0, 0}; ds = '{1, 1}; de = '{'h0FC, 'h191};
`else
    da = '{7, 3, 0}; db = '{7, 4, 0}; dc = '{1, 0, 1}; ds = '{0, 0, 0}; de = '{15, 7, 1};
`endif
    for (int j = 0; j < da.size(); j++) begin
      drive(1'b1, W'(da[j]), W'(db[j]), dc[j][0], ds[j][0], 1'b1, acc, got, sum);
      n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL directed_accept[%0d] got=%b exp=1", j, acc); end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got, sum);
        lat++;
      end
      n_tests++; if (lat !== S || got !== 1'b1) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", j, lat, S); end
      n_tests++; if (sum !== (W+1)'(de[j])) begin n_fail++; $display("FAIL directed_sum[%0d] got=%h exp=%h", j, sum, (W+1)'(de[j])); end
      exp_q = (q.size() > 0) ? q.pop_front() : 'x;
      n_tests++; if (sum !== exp_q) begin n_fail++; $display("FAIL directed_model[%0d] got=%h exp=%h", j, sum, exp_q); end
    end
  endtask

  task automatic test_exhaustive();
    logic acc, got, c, s;
    logic [W:0] sum, exp_q;
    logic [W-1:0] a, b;
    logic [2*W:0] v;
    int cyc, n_out, first_got, last_got, bad_acc, bad_data;
    cyc = 0; n_out = 0; first_got = -1; last_got = -1; bad_acc = 0; bad_data = 0;
    for (int i = 0; i < N_VEC + S + 4; i++) begin
      if (i >= N_VEC && q.size() == 0) break;
`ifdef PIPELINED_ADDER_SUB_MODE_EN
      a = W'($urandom); b = W'($urandom);
      c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
`else
      v = (2*W+1)'(i);
      {a, b, c} = v;
      s = 1'b0;
`endif
      drive(i < N_VEC, a, b, c, s, 1'b1, acc, got, sum);
      if (i < N_VEC && !acc) bad_acc++;
      if (got) begin
        exp_q = (q.size() > 0) ? q.pop_front() : 'x;
        if (sum !== exp_q) begin
          bad_data++;
          $display("FAIL exh_sum[%0d] got=%h exp=%h", n_out, sum, exp_q);
        end
        if (first_got < 0) first_got = cyc;
        last_got = cyc;
        n_out++;
      end
      cyc++;
    end
    n_tests++; if (bad_acc !== 0) begin n_fail++; $display("FAIL exh_in_ready stalls got=%0d exp=0", bad_acc); end
    n_tests++; if (bad_data !== 0) begin n_fail++; $display("FAIL exh_data errors got=%0d exp=0", bad_data); end
    n_tests++; if (n_out !== N_VEC) begin n_fail++; $display("FAIL exh_count got=%0d exp=%0d", n_out, N_VEC); end
    n_tests++; if (first_got !== S) begin n_fail++; $display("FAIL exh_fill got=%0d exp=%0d", first_got, S); end
    n_tests++; if (last_got !== N_VEC + S - 1) begin n_fail++; $display("FAIL exh_throughput got=%0d exp=%0d", last_got, N_VEC + S - 1); end
  endtask

  task automatic test_backpressure();
    logic acc, got;
    logic [W:0] sum, exp_q;
    int idx, n_out;
    idx = 0; n_out = 0;
    for (int k = 0; k < S + 2; k++) begin
      drive(1'b1, W'(idx * 3 + 1), W'(idx + 2), idx[0], 1'b0, 1'b0, acc, got, sum);
      if (acc) idx++;
      if (k < S) begin
        n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_fill_accept[%0d] got=%b exp=1", k, acc); end
      end else begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", k, out_valid); end
        exp_q = (q.size() > 0) ? q[0] : 'x;
        n_tests++; if (sum !== exp_q) begin n_fail++; $display("FAIL bp_hold_sum[%0d] got=%h exp=%h", k, sum, exp_q); end
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (idx >= 5 && q.size() == 0) break;
      drive(idx < 5, W'(idx * 3 + 1), W'(idx + 2), idx[0], 1'b0, 1'b1, acc, got, sum);
      if (acc) idx++;
      if (got) begin
        exp_q = (q.size() > 0) ? q.pop_front() : 'x;
        n_tests++; if (sum !== exp_q) begin n_fail++; $display("FAIL bp_drain_sum[%0d] got=%h exp=%h", n_out, sum, exp_q); end
        n_out++;
      end
    end
    n_tests++; if (n_out !== 5 || idx !== 5) begin n_fail++; $display("FAIL bp_count got=%0d/%0d exp=5/5", n_out, idx); end
  endtask

  task automatic test_bubble();
    logic acc, got;
    logic [W:0] sum, exp_q, x_exp;
    int n_out;
    n_out = 0;
    drive(1'b1, W'(2), W'(5), 1'b1, 1'b0, 1'b0, acc, got, sum);
    x_exp = model(W'(2), W'(5), 1'b1, 1'b0);
    for (int k = 0; k < S - 1; k++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, got, sum);
    drive(1'b1, W'(1), W'(6), 1'b0, 1'b0, 1'b0, acc, got, sum);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bubble_out_valid got=%b exp=1", out_valid); end
    n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bubble_accept got=%b exp=1", acc); end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, got, sum);
    n_tests++; if (sum !== x_exp) begin n_fail++; $display("FAIL bubble_hold_sum got=%h exp=%h", sum, x_exp); end
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got, sum);
      if (got) begin
        exp_q = (q.size() > 0) ? q.pop_front() : 'x;
        n_tests++; if (sum !== exp_q) begin n_fail++; $display("FAIL bubble_drain_sum[%0d] got=%h exp=%h", n_out, sum, exp_q); end
        n_out++;
      end
    end
    n_tests++; if (n_out !== 2) begin n_fail++; $display("FAIL bubble_count got=%0d exp=2", n_out); end
  endtask

  task automatic test_reset_midflight();
    logic acc, got;
    logic [W:0] sum, exp_q;
    int lat;
    drive(1'b1, W'(3), W'(1), 1'b0, 1'b0, 1'b0, acc, got, sum);
    drive(1'b1, W'(1), W'(1), 1'b1, 1'b0, 1'b0, acc, got, sum);
    for (int k = 0; k < S - 1; k++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, got, sum);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_sum !== '0) begin n_fail++; $display("FAIL rst_async_sum got=%h exp=0", out_sum); end
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    drive(1'b1, W'(6), W'(3), 1'b1, 1'b0, 1'b1, acc, got, sum);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got, sum);
      lat++;
    end
    n_tests++; if (lat !== S || got !== 1'b1) begin n_fail++; $display("FAIL rst_post_latency got=%0d exp=%0d", lat, S); end
    exp_q = (q.size() > 0) ? q.pop_front() : 'x;
    n_tests++; if (sum !== exp_q) begin n_fail++; $display("FAIL rst_post_sum got=%h exp=%h", sum, exp_q); end
    n_tests++; if (q.size() !== 0) begin n_fail++; $display("FAIL rst_post_extra got=%0d exp=0", q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
`ifdef PIPELINED_ADDER_SUB_MODE_EN
    in_sub    = 1'b0;
`endif
    test_reset();
    test_directed();
    test_exhaustive();
    test_backpressure();
    test_bubble();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor of the team's small combinational ripple adders with carry-in.
- Computes sum = a + b + cin for WIDTH-bit operands, producing a (WIDTH+1)-bit result (MSB = carry out).
- The carry chain is split into STAGES registered segments, so WIDTH scales without lengthening the critical path.
- Sits between producer and consumer blocks behind valid/ready handshakes on both sides, with full backpressure.

Parameters:
- WIDTH, 3: operand width in bits; must be ≥ STAGES.
- STAGES, 2: number of pipeline segments; must be ≥ 1.
- SEG_W (localparam), ceil(WIDTH/STAGES): bits per segment; the last segment takes the remainder.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input operands valid.
- in_ready  output  1  adder can accept an input this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH+1  {carry_out, sum[WIDTH-1:0]}.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - All stage valid bits clear.
  - out_valid=0, out_sum=0, in_ready=1.
  - Data registers clear to 0.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage k (0..STAGES-1):
  - Holds the partial sum of bits [0 .. (k+1)*SEG_W-1] (clipped to WIDTH).
  - Holds the still-unsummed upper A/B bits.
  - Holds the carry out of segment k and a valid bit v[k].
- Stage 0 adds segment 0 of A, B and cin. Stage k adds segment k of the carried A/B bits plus the stage k-1 carry.
- Advance rule, per stage:
  - adv[STAGES-1] = !v[STAGES-1] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - Stage k loads from upstream when adv[k]. v[k] takes the upstream valid: in_valid for stage 0, v[k-1] for later stages.
- in_ready = adv[0]. This is combinational from out_ready through the valid chain; there is no skid buffer.
- out_valid = v[STAGES-1]; out_sum is the last-stage register.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stalls.
- Throughput: one result per cycle under continuous out_ready=1.
- Bubbles collapse: an empty stage always accepts, even while downstream is stalled.
- Stall: while out_valid && !out_ready, out_sum and out_valid hold stable. No data is lost or duplicated.
- Ordering: strictly in-order; no reordering.
- Inputs are sampled only on transfer. in_a, in_b and in_cin may change freely when not transferring.
- Width arithmetic: out_sum = zero-extended a + b + cin modulo 2^(WIDTH+1). This never overflows: max (2^WIDTH-1)*2+1 = 2^(WIDTH+1)-1.
- Degenerate STAGES=1: single register stage, latency 1.
- Reset mid-operation drops all in-flight results. out_valid falls immediately, asynchronously.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_MODE_EN.
- When defined:
  - Adds port in_sub (input, 1), sampled with the operands.
  - When in_sub=1, B is inverted and the carry-in forced to 1; in_cin is ignored.
  - The result is a − b mod 2^WIDTH in out_sum[WIDTH-1:0].
  - out_sum[WIDTH] = 1 means no borrow (a ≥ b).
  - in_sub travels down the pipeline with its data.
- When undefined: the port is absent and the behaviour is add-only as above.

Test Plan:
- WIDTH=3, STAGES=2:
  - a=7, b=7, cin=1, out_ready=1 → out_valid after 2 cycles, out_sum=4'b1111 (15).
  - a=3, b=4, cin=0 → out_sum=7; a=0, b=0, cin=1 → 1.
- Exhaustive: all 128 {a,b,cin} combinations back-to-back with out_ready=1. Require one result per cycle after 2-cycle fill, in order, each equal to a+b+cin.
- Backpressure:
  - Stream 5 inputs, hold out_ready=0 for 4 cycles. Require in_ready=0 once both stages are full; out_sum holds the first result.
  - Release out_ready → remaining results arrive in order with no loss or duplication.
- Bubble collapse: drive one input, then out_ready=0 with v[1]=1 and v[0]=0. Require in_ready=1 and that the next input is accepted into stage 0.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 results in flight → out_valid=0 and out_sum=0 immediately. After release, in_ready=1 and the first new result has correct latency.
- With PIPELINED_ADDER_SUB_MODE_EN, WIDTH=8, STAGES=3:
  - a=5, b=9, sub=1 → out_sum=9'h0FC.
  - a=200, b=55, sub=1 → 9'h191.
